// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: forwarding source codes,
// the "operand unused" marker and the per-stage pipeline record.
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_E     = 2'b01;
  localparam logic [1:0] FWD_M     = 2'b10;
  localparam logic [1:0] FWD_W     = 2'b11;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // What the controller remembers about an instruction in E, M or W
  typedef struct packed {
    logic [4:0] waddr;
    logic [1:0] tnew;
    logic [4:0] rs;
    logic [4:0] rt;
  } stage_rec_t;

  localparam stage_rec_t STAGE_BUBBLE = '0;

  // One stage of progress brings a result one cycle closer, never below zero
  function automatic logic [1:0] decSat(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // A D-stage operand must wait if the producer in rec cannot deliver in time
  function automatic logic operandStalls(input logic [4:0] src,
                                         input logic [1:0] tuse,
                                         input stage_rec_t rec);
    return (tuse != TUSE_NONE) && (src != 5'd0) &&
           (src == rec.waddr) && (tuse < rec.tnew);
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Priority forwarding selector for one operand. Candidates are ordered
// nearest-first (index 0); the nearest address hit owns the decision even
// when its result is not ready yet, so an older stale copy is never used.
module hazard_fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0]      src_i,
  input  logic [2:0][4:0] candWaddr_i,
  input  logic [2:0][1:0] candTnew_i,
  input  logic [2:0][1:0] candCode_i,
  input  logic [2:0]      candEn_i,
  output logic [1:0]      fwd_o
);

  logic matched;

  // Scan candidates nearest-first; the first hit decides, ready or not
  always_comb begin
    fwd_o   = FWD_RF;
    matched = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (!matched && candEn_i[i] && (src_i != 5'd0) &&
          (candWaddr_i[i] == src_i)) begin
        matched = 1'b1;
        if (candTnew_i[i] == 2'd0) begin
          fwd_o = candCode_i[i];
        end
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks E/M/W destination records, raises a
// stall when a D-stage operand cannot be forwarded in time, and selects the
// forwarding source for the D, E and M stage consumers.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_d,
  input  logic [4:0]  rt_d,
  input  logic [1:0]  tuse_rs,
  input  logic [1:0]  tuse_rt,
  input  logic [1:0]  tnew_d,
  input  logic [4:0]  waddr_d,
  output logic        stall,
  output logic [1:0]  fwd_rs_d,
  output logic [1:0]  fwd_rt_d,
  output logic [1:0]  fwd_rs_e,
  output logic [1:0]  fwd_rt_e,
  output logic        fwd_rt_m,
  output logic [15:0] stall_cnt
);

  stage_rec_t  stageE_q, stageE_d;
  stage_rec_t  stageM_q, stageM_d;
  stage_rec_t  stageW_q, stageW_d;
  logic [15:0] stallCnt_q, stallCnt_d;

  logic        rsStall, rtStall;
  logic [1:0]  rsDSel, rtDSel, rsESel, rtESel, rtMSel;
  logic        unusedOperandFields;

  // Operand fields of M.rs and W are kept for record uniformity only
  assign unusedOperandFields = ^{stageM_q.rs, stageW_q.rs, stageW_q.rt};

  assign rsStall = operandStalls(rs_d, tuse_rs, stageE_q) ||
                   operandStalls(rs_d, tuse_rs, stageM_q);
  assign rtStall = operandStalls(rt_d, tuse_rt, stageE_q) ||
                   operandStalls(rt_d, tuse_rt, stageM_q);

  hazard_fwd_sel uFwdRsD (
    .src_i      (rs_d),
    .candWaddr_i({stageW_q.waddr, stageM_q.waddr, stageE_q.waddr}),
    .candTnew_i ({stageW_q.tnew, stageM_q.tnew, stageE_q.tnew}),
    .candCode_i ({FWD_W, FWD_M, FWD_E}),
    .candEn_i   (3'b111),
    .fwd_o      (rsDSel)
  );

  hazard_fwd_sel uFwdRtD (
    .src_i      (rt_d),
    .candWaddr_i({stageW_q.waddr, stageM_q.waddr, stageE_q.waddr}),
    .candTnew_i ({stageW_q.tnew, stageM_q.tnew, stageE_q.tnew}),
    .candCode_i ({FWD_W, FWD_M, FWD_E}),
    .candEn_i   (3'b111),
    .fwd_o      (rtDSel)
  );

  hazard_fwd_sel uFwdRsE (
    .src_i      (stageE_q.rs),
    .candWaddr_i({5'd0, stageW_q.waddr, stageM_q.waddr}),
    .candTnew_i ({2'd0, stageW_q.tnew, stageM_q.tnew}),
    .candCode_i ({FWD_RF, FWD_W, FWD_M}),
    .candEn_i   (3'b011),
    .fwd_o      (rsESel)
  );

  hazard_fwd_sel uFwdRtE (
    .src_i      (stageE_q.rt),
    .candWaddr_i({5'd0, stageW_q.waddr, stageM_q.waddr}),
    .candTnew_i ({2'd0, stageW_q.tnew, stageM_q.tnew}),
    .candCode_i ({FWD_RF, FWD_W, FWD_M}),
    .candEn_i   (3'b011),
    .fwd_o      (rtESel)
  );

  hazard_fwd_sel uFwdRtM (
    .src_i      (stageM_q.rt),
    .candWaddr_i({5'd0, 5'd0, stageW_q.waddr}),
    .candTnew_i ({2'd0, 2'd0, stageW_q.tnew}),
    .candCode_i ({FWD_RF, FWD_RF, FWD_W}),
    .candEn_i   (3'b001),
    .fwd_o      (rtMSel)
  );

  // Outputs are forced quiet while reset is held, independent of D inputs
  always_comb begin
    stall    = reset & (rsStall | rtStall);
    fwd_rs_d = reset ? rsDSel : FWD_RF;
    fwd_rt_d = reset ? rtDSel : FWD_RF;
    fwd_rs_e = reset ? rsESel : FWD_RF;
    fwd_rt_e = reset ? rtESel : FWD_RF;
    fwd_rt_m = reset & (rtMSel == FWD_W);
  end

  assign stall_cnt = stallCnt_q;

  // Next-state: bubble into E on stall, M and W always advance and age
  always_comb begin
    stageE_d = STAGE_BUBBLE;
    if (!stall) begin
      stageE_d.waddr = waddr_d;
      stageE_d.tnew  = decSat(tnew_d);
      stageE_d.rs    = rs_d;
      stageE_d.rt    = rt_d;
    end
    stageM_d      = stageE_q;
    stageM_d.tnew = decSat(stageE_q.tnew);
    stageW_d      = stageM_q;
    stageW_d.tnew = decSat(stageM_q.tnew);
    stallCnt_d    = stallCnt_q;
    if (stall && (stallCnt_q != 16'hFFFF)) begin
      stallCnt_d = stallCnt_q + 16'd1;
    end
  end

  // Stage records and stall counter, cleared asynchronously by reset low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stageE_q   <= STAGE_BUBBLE;
      stageM_q   <= STAGE_BUBBLE;
      stageW_q   <= STAGE_BUBBLE;
      stallCnt_q <= 16'd0;
    end else begin
      stageE_q   <= stageE_d;
      stageM_q   <= stageM_d;
      stageW_q   <= stageW_d;
      stallCnt_q <= stallCnt_d;
    end
  end

endmodule
